// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Optional macro LEADING_ZERO_BLANK_EN replaces leading zero digits with 4'hF.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 20,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned SCR_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_shift_en;
  logic               w_load_en;

  logic [BIN_W-1:0]   r_shift;
  logic [SCR_W-1:0]   r_scratch;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_flag;
  logic               r_busy;
  logic               r_done;
  logic [SCR_W-1:0]   r_bcd;
  logic               r_overflow;

  logic [SCR_W-1:0]   w_adj;
  logic [SCR_W-1:0]   w_result;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == CNT_W'(1)) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control decode from the current state
  always_comb begin
    w_accept   = 1'b0;
    w_shift_en = 1'b0;
    w_load_en  = 1'b0;
    case (r_state)
      S_IDLE:  w_accept   = start;
      S_SHIFT: w_shift_en = 1'b1;
      S_LOAD:  w_load_en  = 1'b1;
      default: ;
    endcase
  end

  // Add-3 correction on every digit ahead of the shift
  always_comb begin
    w_adj = r_scratch;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic w_seen_nz;

  // Blank zero digits above the most significant nonzero one; digit 0 always shown
  always_comb begin
    w_result  = r_scratch;
    w_seen_nz = 1'b0;
    for (int d = int'(DIGITS) - 1; d >= 1; d--) begin
      if (r_scratch[4*d +: 4] != 4'h0) begin
        w_seen_nz = 1'b1;
      end else if (!w_seen_nz) begin
        w_result[4*d +: 4] = 4'hF;
      end
    end
  end
`else
  assign w_result = r_scratch;
`endif

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_flag <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_busy <= w_shift_en;
      r_done <= w_load_en;
      if (w_accept) begin
        r_shift    <= bin;
        r_scratch  <= '0;
        r_cnt      <= CNT_W'(BIN_W);
        r_ovf_flag <= 1'b0;
      end else if (w_shift_en) begin
        {r_scratch, r_shift} <= {w_adj[SCR_W-2:0], r_shift, 1'b0};
        r_ovf_flag           <= r_ovf_flag | w_adj[SCR_W-1];
        r_cnt                <= r_cnt - CNT_W'(1);
      end
      if (w_load_en) begin
        r_overflow <= r_ovf_flag;
        r_bcd      <= r_ovf_flag ? {SCR_W{1'b1}} : w_result;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: directed and random conversions against an arithmetic model.
// Honours LEADING_ZERO_BLANK_EN the same way as the design build.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [19:0] bin;
  logic        busy;
  logic        done;
  logic [23:0] bcd;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {overflow, bcd} from decimal arithmetic
  function automatic logic [24:0] model(input int unsigned v);
    logic [23:0] b;
    int unsigned p;
    b = '0;
    if (v > 999999) return {1'b1, 24'hFFFFFF};
    p = 1;
    for (int d = 0; d < 6; d++) begin
      b[4*d +: 4] = 4'((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && v < p) b[4*d +: 4] = 4'hF;
`endif
      p = p * 10;
    end
    return {1'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive start with a value and return just after the accepting edge
  task automatic kick(input logic [19:0] v);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done (bounded); also count busy cycles and bcd changes
  task automatic wait_done(output int cyc, output int bcnt, output int glitch);
    logic [23:0] held;
    held   = bcd;
    cyc    = 0;
    bcnt   = 0;
    glitch = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) bcnt++;
      if (!done && bcd !== held) glitch++;
    end
  endtask

  task automatic convert(input string tag, input logic [19:0] v);
    int cyc, bcnt, glitch;
    logic [24:0] exp;
    exp = model(int'(v));
    kick(v);
    wait_done(cyc, bcnt, glitch);
    chk({tag, "_latency"}, 32'(cyc), 32'd21);
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd20);
    chk({tag, "_no_glitch"}, 32'(glitch), 32'd0);
    chk({tag, "_bcd"}, 32'(bcd), 32'(exp[23:0]));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp[24]));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc, bcnt, glitch, ndone, first_d, last_d;
    logic [24:0] exp;
    logic [19:0] rv;

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    convert("zero", 20'd0);
    convert("max6", 20'd999999);
    convert("v123456", 20'd123456);
    convert("v100000", 20'd100000);
    convert("v42", 20'd42);
    convert("ovf_1e6", 20'd1000000);
    convert("ovf_max", 20'hFFFFF);
    convert("after_ovf", 20'd7);

    for (int i = 0; i < 8; i++) begin
      rv = 20'($urandom_range(0, 1048575));
      convert($sformatf("rand%0d", i), rv);
    end

    // start while busy is ignored and bin changes are not picked up
    kick(20'd42);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bin   = 20'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bcnt, glitch);
    chk("ignore_latency", 32'(cyc), 32'd16);
    exp = model(42);
    chk("ignore_bcd", 32'(bcd), 32'(exp[23:0]));
    repeat (3) @(posedge clk);
    #1;
    chk("ignore_not_queued", 32'(busy), 32'd0);

    // start held high: back-to-back conversions every 22 clocks
    @(negedge clk);
    bin   = 20'd555555;
    start = 1'b1;
    @(posedge clk);
    #1;
    ndone   = 0;
    first_d = -1;
    last_d  = -1;
    for (int c = 1; c <= 200 && ndone < 3; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (ndone == 1) first_d = c;
        else chk($sformatf("b2b_interval%0d", ndone), 32'(c - last_d), 32'd22);
        last_d = c;
        exp = model(555555);
        chk($sformatf("b2b_bcd%0d", ndone), 32'(bcd), 32'(exp[23:0]));
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(ndone), 32'd3);
    chk("b2b_first", 32'(first_d), 32'd21);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_idle", 32'(busy), 32'd0);

    // reset mid-conversion abandons it
    kick(20'd500000);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_bcd", 32'(bcd), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    convert("post_rst", 20'd654321);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
